pb_spi_master: RTL and testbench
================================

// Module: pb_spi_master
// PURPOSE
//  Port-mapped SPI master on the KCPSM6 I/O bus. It decodes port_id, write_strobe and
//  read_strobe from the cpu block and returns in_port data, so the PicoBlaze can drive
//  the PMOD ACL2 accelerometer. Mode 0 (CPOL=0, CPHA=0), MSB first, one byte per transfer.
//  Raises interrupt on byte completion and holds it until interrupt_ack.
// PARAMETERS
//  BASE_ADDR  8'h10  port base; bits [1:0] must be 0; block occupies BASE_ADDR..BASE_ADDR+3
//  DIV_RESET  8'd4   reset value of CLKDIV
// PORTS
//  clk_sys        in   1  system clock
//  reset_sys      in   1  synchronous, active-high reset
//  port_id        in   8  KCPSM6 port address
//  out_port       in   8  KCPSM6 write data
//  write_strobe   in   1  KCPSM6 OUTPUT strobe, one cycle
//  read_strobe    in   1  KCPSM6 INPUT strobe, one cycle
//  in_port        out  8  read data; 8'h00 when port_id is not decoded, so buses can be ORed
//  interrupt      out  1  level interrupt request to KCPSM6
//  interrupt_ack  in   1  KCPSM6 acknowledge, one cycle
//  spi_sclk       out  1  SPI clock, idles low
//  spi_mosi       out  1  SPI data out
//  spi_miso       in   1  SPI data in; treated as synchronous
//  spi_cs_n       out  1  chip select, active low
// BEHAVIOUR
//  Decode: hit = (port_id[7:2] == BASE_ADDR[7:2]); register offset = port_id[1:0].
//   0 DATA    W: load TX byte and start a transfer; R: last received byte
//   1 CTRL    RW: bit0 CS_EN (spi_cs_n = ~CS_EN), bit1 INT_EN; bits 7:2 read 0
//   2 STATUS  R: bit0 BUSY, bit1 DONE (sticky), bit2 OVERRUN (sticky); others read 0
//             A read_strobe at offset 2 clears DONE and OVERRUN.
//   3 CLKDIV  RW: each sclk half-period = CLKDIV+1 clk_sys cycles
//  in_port is registered and updated every cycle from port_id. It is valid one cycle after
//   port_id changes, which meets KCPSM6 two-cycle INPUT timing.
//  Reset values: in_port 0, interrupt 0, spi_sclk 0, spi_mosi 0, spi_cs_n 1, DATA_RX 0,
//   CTRL 0, STATUS 0, CLKDIV DIV_RESET, FSM IDLE, shift/bit/divider counters 0.
//  FSM states: IDLE, LOW, HIGH.
//   IDLE: a write to DATA loads the shift register and sets spi_mosi = bit7 and BUSY=1 on
//    the next edge; divider and bit_cnt clear; go to LOW.
//   LOW: spi_sclk=0. When divider reaches CLKDIV, sample spi_miso into rx_shift[0], set
//    spi_sclk=1, and go to HIGH.
//   HIGH: spi_sclk=1. When divider reaches CLKDIV, set spi_sclk=0.
//    If bit_cnt==7: DATA_RX <= rx_shift, BUSY=0, DONE=1, interrupt=INT_EN, go to IDLE.
//    Otherwise: shift to the next MOSI bit, bit_cnt++, go to LOW.
//   Divider clears on every state change.
//   Transfer length: 16*(CLKDIV+1) cycles from the strobe edge to BUSY falling.
//  A DATA write while BUSY is ignored (TX and transfer untouched) and sets OVERRUN.
//  A CLKDIV write while BUSY takes effect on the next divider compare. Firmware must not do this.
//  CS_EN is independent of the FSM; multi-byte frames hold CS_EN=1 across transfers.
//  interrupt clears on interrupt_ack or when INT_EN is written 0. It does not clear DONE.
//  Simultaneous events: set beats clear.
//   - Completion in the same cycle as interrupt_ack: interrupt stays 1.
//   - Completion in the same cycle as a STATUS read: DONE stays 1.
//  Writes and reads to non-hit port_id have no effect; writes to STATUS are ignored.
//  reset_sys mid-transfer aborts immediately: sclk 0, cs_n 1, no DONE, no interrupt.
// TESTING
//  1 CLKDIV=1, CTRL=1, write DATA=8'hA5, slave returns 8'h3C.
//    -> MOSI bits 1,0,1,0,0,1,0,1 on rising sclk; 8 sclk pulses of 2+2 cycles;
//       BUSY low after 32 cycles; DATA reads 8'h3C; STATUS reads 8'h02, then 8'h00.
//  2 INT_EN=1, complete a transfer -> interrupt=1 held until interrupt_ack; DONE stays 1.
//    Then assert ack on the completion cycle of a second transfer -> interrupt remains 1.
//  3 Write DATA=8'h11 then 8'h22 while BUSY -> MOSI shifts 8'h11 only; STATUS reads 8'h05 mid-transfer.
//  4 Read port_id BASE_ADDR+4 and 8'h00 -> in_port 8'h00; CTRL reads back 8'h03 after writing 8'hFF.
//  5 reset_sys at bit 4 of a transfer -> next cycle sclk 0, cs_n 1, BUSY 0, DONE 0, CLKDIV=DIV_RESET.
//  6 CLKDIV=0 back-to-back bytes with CS_EN held -> cs_n stays low; 16 cycles per byte.

Source files
------------

// File: rtl/pb_spi_master.sv
// rtl/pb_spi_master.sv - KCPSM6 port-mapped SPI master, mode 0, MSB first, one byte per transfer
// Registers: DATA, CTRL, STATUS, CLKDIV at BASE_ADDR..BASE_ADDR+3; level interrupt on byte done.
module pb_spi_master #(
   parameter logic [7:0] BASE_ADDR = 8'h10,
   parameter logic [7:0] DIV_RESET = 8'd4
) (
   input  logic       clk_sys,
   input  logic       reset_sys,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       write_strobe,
   input  logic       read_strobe,
   output logic [7:0] in_port,
   output logic       interrupt,
   input  logic       interrupt_ack,
   output logic       spi_sclk,
   output logic       spi_mosi,
   input  logic       spi_miso,
   output logic       spi_cs_n
);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   state_t     state;
   state_t     next_state;

   logic       hit;
   logic [1:0] offset;
   logic       wr_data;
   logic       wr_ctrl;
   logic       wr_div;
   logic       rd_status;

   logic [7:0] tx_shift;
   logic [7:0] rx_shift;
   logic [7:0] data_rx;
   logic [7:0] clkdiv;
   logic [7:0] divider;
   logic [2:0] bit_cnt;
   logic       cs_en;
   logic       int_en;
   logic       busy;
   logic       done;
   logic       overrun;

   logic       div_hit;
   logic       start;
   logic       rise;
   logic       shift;
   logic       finish;
   logic [7:0] read_mux;

   assign hit       = (port_id[7:2] == BASE_ADDR[7:2]);
   assign offset    = port_id[1:0];
   assign wr_data   = write_strobe && hit && (offset == 2'd0);
   assign wr_ctrl   = write_strobe && hit && (offset == 2'd1);
   assign wr_div    = write_strobe && hit && (offset == 2'd3);
   assign rd_status = read_strobe  && hit && (offset == 2'd2);
   assign div_hit   = (divider == clkdiv);
   assign spi_cs_n  = ~cs_en;

   always_ff @(posedge clk_sys) begin
      if (reset_sys) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      start      = 1'b0;
      rise       = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (wr_data) begin
               start      = 1'b1;
               next_state = LOW;
            end
         end
         LOW: begin
            if (div_hit) begin
               rise       = 1'b1;
               next_state = HIGH;
            end
         end
         HIGH: begin
            if (div_hit) begin
               if (bit_cnt == 3'd7) begin
                  finish     = 1'b1;
                  next_state = IDLE;
               end else begin
                  shift      = 1'b1;
                  next_state = LOW;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      read_mux = 8'h00;
      if (hit) begin
         case (offset)
            2'd0:    read_mux = data_rx;
            2'd1:    read_mux = {6'b0, int_en, cs_en};
            2'd2:    read_mux = {5'b0, overrun, done, busy};
            default: read_mux = clkdiv;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset_sys) begin
         tx_shift  <= 8'h00;
         rx_shift  <= 8'h00;
         data_rx   <= 8'h00;
         clkdiv    <= DIV_RESET;
         divider   <= 8'h00;
         bit_cnt   <= 3'd0;
         cs_en     <= 1'b0;
         int_en    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
         interrupt <= 1'b0;
         spi_sclk  <= 1'b0;
         spi_mosi  <= 1'b0;
         in_port   <= 8'h00;
      end else begin
         // Half-period counter restarts on every state change and idles at zero.
         if ((state != next_state) || (state == IDLE)) begin
            divider <= 8'h00;
         end else begin
            divider <= divider + 8'd1;
         end

         if (start) begin
            tx_shift <= out_port;
            spi_mosi <= out_port[7];
            rx_shift <= 8'h00;
            bit_cnt  <= 3'd0;
            busy     <= 1'b1;
         end
         if (rise) begin
            rx_shift <= {rx_shift[6:0], spi_miso};
            spi_sclk <= 1'b1;
         end
         if (shift) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
            spi_mosi <= tx_shift[6];
            bit_cnt  <= bit_cnt + 3'd1;
            spi_sclk <= 1'b0;
         end
         if (finish) begin
            data_rx  <= rx_shift;
            busy     <= 1'b0;
            spi_sclk <= 1'b0;
         end

         if (wr_ctrl) begin
            cs_en  <= out_port[0];
            int_en <= out_port[1];
         end
         if (wr_div) begin
            clkdiv <= out_port;
         end

         // Set beats clear for the sticky flags and the interrupt request.
         if (finish) begin
            done <= 1'b1;
         end else if (rd_status) begin
            done <= 1'b0;
         end

         if (wr_data && busy) begin
            overrun <= 1'b1;
         end else if (rd_status) begin
            overrun <= 1'b0;
         end

         if (finish && int_en) begin
            interrupt <= 1'b1;
         end else if (interrupt_ack || (wr_ctrl && !out_port[1])) begin
            interrupt <= 1'b0;
         end

         in_port <= read_mux;
      end
   end

endmodule

// File: tb/tb_pb_spi_master.sv
// tb/tb_pb_spi_master.sv - directed self-checking bench for pb_spi_master
// A small SPI slave returns slave_byte MSB first and records MOSI on each rising sclk.
module tb_pb_spi_master;

   localparam logic [7:0] A_DATA = 8'h10;
   localparam logic [7:0] A_CTRL = 8'h11;
   localparam logic [7:0] A_STAT = 8'h12;
   localparam logic [7:0] A_DIV  = 8'h13;

   logic       clk_sys = 1'b0;
   logic       reset_sys = 1'b1;
   logic [7:0] port_id = 8'h00;
   logic [7:0] out_port = 8'h00;
   logic       write_strobe = 1'b0;
   logic       read_strobe = 1'b0;
   logic [7:0] in_port;
   logic       interrupt;
   logic       interrupt_ack = 1'b0;
   logic       spi_sclk;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_cs_n;

   int         n_checks = 0;
   int         n_fail = 0;

   int         rise_cnt = 0;
   int         slave_base = 0;
   logic [7:0] slave_byte = 8'h00;
   logic [7:0] mosi_cap = 8'h00;
   logic [2:0] sidx;

   pb_spi_master #(.BASE_ADDR(8'h10), .DIV_RESET(8'd4)) dut (
      .clk_sys       (clk_sys),
      .reset_sys     (reset_sys),
      .port_id       (port_id),
      .out_port      (out_port),
      .write_strobe  (write_strobe),
      .read_strobe   (read_strobe),
      .in_port       (in_port),
      .interrupt     (interrupt),
      .interrupt_ack (interrupt_ack),
      .spi_sclk      (spi_sclk),
      .spi_mosi      (spi_mosi),
      .spi_miso      (spi_miso),
      .spi_cs_n      (spi_cs_n)
   );

   always #5 clk_sys = ~clk_sys;

   always @(posedge spi_sclk) begin
      rise_cnt <= rise_cnt + 1;
      mosi_cap <= {mosi_cap[6:0], spi_mosi};
   end

   always_comb begin
      sidx     = 3'(rise_cnt - slave_base);
      spi_miso = slave_byte[3'd7 - sidx];
   end

   task automatic wr(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk_sys);
      port_id      = addr;
      out_port     = data;
      write_strobe = 1'b1;
      @(negedge clk_sys);
      write_strobe = 1'b0;
   endtask

   task automatic rd(input logic [7:0] addr, output logic [7:0] data);
      @(negedge clk_sys);
      port_id     = addr;
      @(negedge clk_sys);
      read_strobe = 1'b1;
      data        = in_port;
      @(negedge clk_sys);
      read_strobe = 1'b0;
   endtask

   task automatic slave_load(input logic [7:0] b);
      slave_byte = b;
      slave_base = rise_cnt;
   endtask

   // Called right after a DATA write; counts cycles BUSY is seen high via STATUS.
   task automatic wait_idle(input int limit, output int cycles, output int highs, output int csn_hi);
      cycles  = 0;
      highs   = 0;
      csn_hi  = 0;
      port_id = A_STAT;
      while (cycles < limit) begin
         @(negedge clk_sys);
         if (in_port[0] == 1'b0) break;
         cycles = cycles + 1;
         highs  = highs + int'(spi_sclk);
         csn_hi = csn_hi + int'(spi_cs_n);
      end
   endtask

   task automatic test_reset;
      logic [7:0] v;
      reset_sys = 1'b1;
      repeat (3) @(negedge clk_sys);
      reset_sys = 1'b0;
      n_checks++; if (in_port !== 8'h00) begin n_fail++; $display("FAIL reset_in_port: got %h want 00", in_port); end
      n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", interrupt); end
      n_checks++; if (spi_sclk !== 1'b0 || spi_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_sclk_mosi: got %b%b want 00", spi_sclk, spi_mosi); end
      n_checks++; if (spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", spi_cs_n); end
      rd(A_DIV, v);
      n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL reset_clkdiv: got %h want 04", v); end
      rd(A_CTRL, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h want 00", v); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_status: got %h want 00", v); end
      rd(A_DATA, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", v); end
   endtask

   task automatic test_basic_transfer;
      logic [7:0] v;
      int cyc, hi, csh, base;
      wr(A_DIV, 8'h01);
      wr(A_CTRL, 8'h01);
      n_checks++; if (spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL basic_cs_low: got %b want 0", spi_cs_n); end
      slave_load(8'h3C);
      base = rise_cnt;
      wr(A_DATA, 8'hA5);
      wait_idle(200, cyc, hi, csh);
      n_checks++; if (cyc != 32) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 32", cyc); end
      n_checks++; if (hi != 16) begin n_fail++; $display("FAIL basic_sclk_high_cycles: got %0d want 16", hi); end
      n_checks++; if (rise_cnt - base != 8) begin n_fail++; $display("FAIL basic_sclk_pulses: got %0d want 8", rise_cnt - base); end
      n_checks++; if (mosi_cap !== 8'hA5) begin n_fail++; $display("FAIL basic_mosi: got %h want a5", mosi_cap); end
      n_checks++; if (csh != 0) begin n_fail++; $display("FAIL basic_cs_held: got %0d high cycles want 0", csh); end
      rd(A_DATA, v);
      n_checks++; if (v !== 8'h3C) begin n_fail++; $display("FAIL basic_rx_data: got %h want 3c", v); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL basic_status_done: got %h want 02", v); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL basic_status_cleared: got %h want 00", v); end
   endtask

   task automatic test_interrupt;
      logic [7:0] v;
      int cyc, hi, csh;
      wr(A_CTRL, 8'h03);
      slave_load(8'h5A);
      wr(A_DATA, 8'h81);
      wait_idle(200, cyc, hi, csh);
      n_checks++; if (cyc != 32) begin n_fail++; $display("FAIL irq_busy_cycles: got %0d want 32", cyc); end
      n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_raised: got %b want 1", interrupt); end
      repeat (5) @(negedge clk_sys);
      n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_held: got %b want 1", interrupt); end
      interrupt_ack = 1'b1;
      @(negedge clk_sys);
      interrupt_ack = 1'b0;
      n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_ack_clear: got %b want 0", interrupt); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL irq_done_kept: got %h want 02", v); end
      slave_load(8'h00);
      wr(A_DATA, 8'h42);
      repeat (31) @(negedge clk_sys);
      n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_before_done: got %b want 0", interrupt); end
      interrupt_ack = 1'b1;
      @(negedge clk_sys);
      interrupt_ack = 1'b0;
      n_checks++; if (interrupt !== 1'b1) begin n_fail++; $display("FAIL irq_set_beats_ack: got %b want 1", interrupt); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL irq_status2: got %h want 02", v); end
      wr(A_CTRL, 8'h01);
      n_checks++; if (interrupt !== 1'b0) begin n_fail++; $display("FAIL irq_inten_clear: got %b want 0", interrupt); end
   endtask

   task automatic test_overrun;
      logic [7:0] v;
      int cyc, hi, csh;
      slave_load(8'h96);
      wr(A_DATA, 8'h11);
      wr(A_DATA, 8'h22);
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h05) begin n_fail++; $display("FAIL ovr_status_mid: got %h want 05", v); end
      wait_idle(200, cyc, hi, csh);
      n_checks++; if (mosi_cap !== 8'h11) begin n_fail++; $display("FAIL ovr_mosi: got %h want 11", mosi_cap); end
      rd(A_DATA, v);
      n_checks++; if (v !== 8'h96) begin n_fail++; $display("FAIL ovr_rx_data: got %h want 96", v); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL ovr_status_end: got %h want 02", v); end
   endtask

   task automatic test_decode;
      logic [7:0] v;
      wr(A_CTRL, 8'hFF);
      rd(A_CTRL, v);
      n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL dec_ctrl_readback: got %h want 03", v); end
      rd(8'h14, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL dec_read_base_plus4: got %h want 00", v); end
      rd(8'h00, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL dec_read_00: got %h want 00", v); end
      wr(8'h15, 8'h00);
      wr(8'h17, 8'h55);
      wr(A_STAT, 8'hFF);
      rd(A_CTRL, v);
      n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL dec_alias_ctrl: got %h want 03", v); end
      rd(A_DIV, v);
      n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL dec_alias_clkdiv: got %h want 01", v); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL dec_status_write: got %h want 00", v); end
      wr(A_CTRL, 8'h00);
   endtask

   task automatic test_reset_mid;
      logic [7:0] v;
      int base;
      wr(A_CTRL, 8'h03);
      slave_load(8'hFF);
      base = rise_cnt;
      wr(A_DATA, 8'hC3);
      repeat (18) @(negedge clk_sys);
      n_checks++; if (spi_sclk !== 1'b1 || rise_cnt - base != 5) begin n_fail++; $display("FAIL rst_mid_pre: got sclk %b pulses %0d want 1 5", spi_sclk, rise_cnt - base); end
      reset_sys = 1'b1;
      @(negedge clk_sys);
      reset_sys = 1'b0;
      n_checks++; if (spi_sclk !== 1'b0 || spi_cs_n !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pins: got sclk %b cs_n %b want 0 1", spi_sclk, spi_cs_n); end
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL rst_mid_status: got %h want 00", v); end
      rd(A_DIV, v);
      n_checks++; if (v !== 8'h04) begin n_fail++; $display("FAIL rst_mid_clkdiv: got %h want 04", v); end
      repeat (40) @(negedge clk_sys);
      rd(A_STAT, v);
      n_checks++; if (v !== 8'h00 || interrupt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got status %h irq %b want 00 0", v, interrupt); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] v;
      int cyc, hi, csh;
      wr(A_DIV, 8'h00);
      wr(A_CTRL, 8'h01);
      slave_load(8'hE7);
      wr(A_DATA, 8'h3F);
      wait_idle(200, cyc, hi, csh);
      n_checks++; if (cyc != 16 || hi != 8) begin n_fail++; $display("FAIL b2b_byte1_timing: got %0d/%0d want 16/8", cyc, hi); end
      n_checks++; if (mosi_cap !== 8'h3F) begin n_fail++; $display("FAIL b2b_byte1_mosi: got %h want 3f", mosi_cap); end
      n_checks++; if (csh != 0 || spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL b2b_cs1: got %0d high cycles, cs_n %b want 0 0", csh, spi_cs_n); end
      slave_load(8'h18);
      wr(A_DATA, 8'hC4);
      wait_idle(200, cyc, hi, csh);
      n_checks++; if (cyc != 16 || hi != 8) begin n_fail++; $display("FAIL b2b_byte2_timing: got %0d/%0d want 16/8", cyc, hi); end
      n_checks++; if (mosi_cap !== 8'hC4) begin n_fail++; $display("FAIL b2b_byte2_mosi: got %h want c4", mosi_cap); end
      n_checks++; if (csh != 0 || spi_cs_n !== 1'b0) begin n_fail++; $display("FAIL b2b_cs2: got %0d high cycles, cs_n %b want 0 0", csh, spi_cs_n); end
      rd(A_DATA, v);
      n_checks++; if (v !== 8'h18) begin n_fail++; $display("FAIL b2b_rx_data: got %h want 18", v); end
   endtask

   initial begin
      test_reset();
      test_basic_transfer();
      test_interrupt();
      test_overrun();
      test_decode();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
